// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_pkg -- shared types and defaults for the bit-serial adder slice.
//   state_t          : controller FSM encoding (IDLE, ADD, DONE)
//   DEFAULT_NUM_BITS : default operand/result width
package serial_add_pkg;

   localparam int DEFAULT_NUM_BITS = 32'd8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if -- start/done request bus between a datapath and the
// bit-serial addition controller.
//   start, a, b, carry_in : request and operands (driven by master)
//   busy, done            : progress/completion status (driven by slave)
//   sum, carry_out        : held result of the last completed addition
interface serial_add_ctrl_if #(
   parameter int NUM_BITS = 32'd8
);

   logic                start;
   logic [NUM_BITS-1:0] a;
   logic [NUM_BITS-1:0] b;
   logic                carry_in;
   logic                busy;
   logic                done;
   logic [NUM_BITS-1:0] sum;
   logic                carry_out;

   modport master (
      output start, a, b, carry_in,
      input  busy, done, sum, carry_out
   );

   modport slave (
      input  start, a, b, carry_in,
      output busy, done, sum, carry_out
   );

endinterface

// File: rtl/serial_add_ctrl_adder_1bit.sv
// adder_1bit -- combinational single-bit full adder.
//   a, b, cin : addend bits and incoming carry
//   sum, cout : sum bit and outgoing carry
module adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl -- adds two NUM_BITS operands LSB first through one shared
// full adder, one bit per clock, and holds the result until the next run.
//   clk   : rising-edge clock
//   n_rst : asynchronous active-low reset
//   bus   : serial_add_ctrl_if slave (start/a/b/carry_in in,
//           busy/done/sum/carry_out out)
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
   input  logic               clk,
   input  logic               n_rst,
   serial_add_ctrl_if.slave   bus
);

   localparam int                CNT_W    = $clog2(NUM_BITS);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_BITS - 1);

   state_t              state_r;
   logic [NUM_BITS-1:0] a_shreg_r;
   logic [NUM_BITS-1:0] b_shreg_r;
   // Only the upper NUM_BITS-1 result bits are kept: the lowest bit of the
   // conceptual result shift register would be shifted out before anyone
   // could read it, so it never needs storage.
   logic [NUM_BITS-2:0] result_shreg_r;
   logic                carry_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [NUM_BITS-1:0] sum_r;
   logic                carry_out_r;

   logic                fa_sum_s;
   logic                fa_cout_s;
   logic [NUM_BITS-1:0] result_next_s;

   adder_1bit u_adder (
      .a    (a_shreg_r[0]),
      .b    (b_shreg_r[0]),
      .cin  (carry_r),
      .sum  (fa_sum_s),
      .cout (fa_cout_s)
   );

   // New sum bit enters at the MSB; the complete word is ready on the last bit.
   assign result_next_s = {fa_sum_s, result_shreg_r};

   // Controller FSM with operand/result shift registers and held outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_r        <= IDLE;
         a_shreg_r      <= '0;
         b_shreg_r      <= '0;
         result_shreg_r <= '0;
         carry_r        <= 1'b0;
         cnt_r          <= '0;
         sum_r          <= '0;
         carry_out_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  a_shreg_r <= bus.a;
                  b_shreg_r <= bus.b;
                  carry_r   <= bus.carry_in;
                  cnt_r     <= '0;
                  state_r   <= ADD;
               end else begin
                  state_r   <= IDLE;
               end
            end
            ADD: begin
               a_shreg_r      <= {1'b0, a_shreg_r[NUM_BITS-1:1]};
               b_shreg_r      <= {1'b0, b_shreg_r[NUM_BITS-1:1]};
               result_shreg_r <= result_next_s[NUM_BITS-1:1];
               carry_r        <= fa_cout_s;
               cnt_r          <= cnt_r + CNT_W'(1);
               if (cnt_r == LAST_CNT) begin
                  sum_r       <= result_next_s;
                  carry_out_r <= fa_cout_s;
                  state_r     <= DONE;
               end else begin
                  state_r     <= ADD;
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy      = (state_r == ADD);
   assign bus.done      = (state_r == DONE);
   assign bus.sum       = sum_r;
   assign bus.carry_out = carry_out_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl -- directed bench for serial_add_ctrl (NUM_BITS=8).
module tb_serial_add_ctrl;

   localparam int NB = 8;

   logic clk;
   logic n_rst;
   int   n_vec;
   int   n_miss;

   logic [NB-1:0] last_sum;
   logic          last_cout;

   serial_add_ctrl_if #(.NUM_BITS(NB)) bus ();

   serial_add_ctrl #(.NUM_BITS(NB)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".busy"}, 32'(bus.busy), 32'd0);
      check({tag, ".done"}, 32'(bus.done), 32'd0);
      check({tag, ".sum"},  32'(bus.sum), 32'(last_sum));
      check({tag, ".cout"}, 32'(bus.carry_out), 32'(last_cout));
   endtask

   // One full operation; poke >= 0 fires an extra start (0xFF+0xFF) during busy.
   task automatic run_add(input string tag, input logic [NB-1:0] a_v, input logic [NB-1:0] b_v,
                          input logic cin_v, input logic [NB-1:0] exp_sum, input logic exp_cout,
                          input int poke);
      @(negedge clk);
      bus.start = 1'b1; bus.a = a_v; bus.b = b_v; bus.carry_in = cin_v;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a = ~a_v; bus.b = ~b_v; bus.carry_in = ~cin_v;
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         check({tag, ".busy"}, 32'(bus.busy), 32'd1);
         check({tag, ".nodone"}, 32'(bus.done), 32'd0);
         check({tag, ".hold_sum"}, 32'(bus.sum), 32'(last_sum));
         if (i == poke) begin
            bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
         end else begin
            bus.start = 1'b0;
         end
      end
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, ".done"}, 32'(bus.done), 32'd1);
      check({tag, ".busy_low"}, 32'(bus.busy), 32'd0);
      check({tag, ".sum"}, 32'(bus.sum), 32'(exp_sum));
      check({tag, ".cout"}, 32'(bus.carry_out), 32'(exp_cout));
      last_sum  = exp_sum;
      last_cout = exp_cout;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_idle_outputs({tag, ".after"});
      end
   endtask

   initial begin
      int done_cnt;
      int prev_done;
      n_vec = 0; n_miss = 0;
      last_sum = '0; last_cout = 1'b0;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.carry_in = 1'b0;
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      n_rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_idle_outputs("idle");
      end

      run_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, -1);
      run_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, -1);
      run_add("add_ff_00_c", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, -1);
      run_add("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, -1);
      run_add("add_12_34_poke", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 3);
      run_add("add_40_41_pokelast", 8'h40, 8'h41, 1'b1, 8'h82, 1'b0, NB - 1);

      // Reset in the middle of an addition discards it.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.carry_in = 1'b0;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (4) @(negedge clk);
      n_rst = 1'b0;
      #1;
      last_sum = '0; last_cout = 1'b0;
      check_idle_outputs("midrst");
      @(negedge clk);
      n_rst = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.done) done_cnt++;
         check("midrst.nobusy", 32'(bus.busy), 32'd0);
      end
      check("midrst.no_done", 32'(done_cnt), 32'd0);
      check("midrst.sum_zero", 32'(bus.sum), 32'd0);
      run_add("add_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, -1);

      // Start held high: one acceptance every NB+2 cycles.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h11; bus.b = 8'h22; bus.carry_in = 1'b0;
      done_cnt = 0;
      prev_done = -1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         check("b2b.not_both", 32'(bus.busy & bus.done), 32'd0);
         if (bus.done) begin
            done_cnt++;
            check("b2b.sum", 32'(bus.sum), 32'h33);
            if (prev_done < 0) check("b2b.first_done", 32'(n), 32'(NB + 1));
            else               check("b2b.spacing", 32'(n - prev_done), 32'(NB + 2));
            prev_done = n;
         end
         if (n == 50) bus.start = 1'b0;
      end
      check("b2b.done_count", 32'(done_cnt), 32'd5);
      last_sum = 8'h33; last_cout = 1'b0;
      repeat (2) @(negedge clk);
      check_idle_outputs("b2b.end");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
